// File: rtl/receive_pkg.sv
// Shared 1000BASE-X PCS definitions: code-group constants, state
// encodings and helpers used by the receive and transmit paths.
package receive_pkg;

    localparam logic [7:0] K28_5   = 8'hBC;
    localparam logic [7:0] K27_7_S = 8'hFB;
    localparam logic [7:0] K29_7_T = 8'hFD;
    localparam logic [7:0] K23_7_R = 8'hF7;
    localparam logic [7:0] K30_7_V = 8'hFE;
    localparam logic [7:0] D_I1    = 8'hC5;
    localparam logic [7:0] D_I2    = 8'h50;

    localparam logic [7:0] RXD_PREAMBLE = 8'h55;
    localparam logic [7:0] RXD_FALSE_CS = 8'h0E;

    // Transmit side: configuration ordered-set data and xmit modes
    localparam logic [7:0] D21_5_C1 = 8'hB5;
    localparam logic [7:0] D2_2_C2  = 8'h42;

    typedef enum logic [1:0] {
        XMIT_IDLE,
        XMIT_CONFIG,
        XMIT_DATA
    } xmit_t;

    typedef struct packed {
        logic [7:0] octet;
        logic       is_k;
        logic       valid;
    } cg_t;

    localparam cg_t CG_RESET = '{octet: 8'h00, is_k: 1'b0, valid: 1'b1};

    typedef enum logic [3:0] {
        LINK_FAILED,
        WAIT_FOR_K,
        RX_K,
        IDLE_D,
        FALSE_CARRIER,
        START_OF_PACKET,
        RECEIVE,
        RX_DATA_ERROR,
        EARLY_END,
        TRI_RRI
    } rx_state_t;

    function automatic logic cg_is_k(input cg_t cg, input logic [7:0] code);
        return cg.valid && cg.is_k && (cg.octet == code);
    endfunction

    function automatic logic cg_is_d(input cg_t cg);
        return cg.valid && !cg.is_k;
    endfunction

    function automatic logic cg_is_idle_d(input cg_t cg);
        return cg_is_d(cg) && ((cg.octet == D_I1) || (cg.octet == D_I2));
    endfunction

endpackage

// File: rtl/receive_lookahead.sv
// Three-deep code-group shift register: LA2 -> LA1 -> CUR, giving the
// receive FSM two code-groups of lookahead for /T/R/K28.5 detection.
module rx_lookahead
    import receive_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  cg_t  i_cg,
    output cg_t  o_cur,
    output cg_t  o_la1,
    output cg_t  o_la2
);

    cg_t r_la2;
    cg_t r_la1;
    cg_t r_cur;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_la2 <= CG_RESET;
            r_la1 <= CG_RESET;
            r_cur <= CG_RESET;
        end else begin
            r_la2 <= i_cg;
            r_la1 <= r_la2;
            r_cur <= r_la1;
        end
    end

    assign o_cur = r_cur;
    assign o_la1 = r_la1;
    assign o_la2 = r_la2;

endmodule

// File: rtl/receive.sv
// 1000BASE-X PCS receive: converts decoded code-groups into GMII
// RXD/RX_DV/RX_ER with registered outputs.
module receive
    import receive_pkg::*;
(
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic       sync_status,
    input  logic [7:0] rx_octet,
    input  logic       rx_is_k,
    input  logic       rx_code_valid,
    output logic [7:0] RXD,
    output logic       RX_DV,
    output logic       RX_ER,
    output logic       receiving
);

    cg_t       w_in;
    cg_t       w_cur;
    cg_t       w_la1;
    cg_t       w_la2;
    rx_state_t r_state;
    rx_state_t w_nxt;
    logic [7:0] r_rxd;
    logic       r_dv;
    logic       r_er;
    logic       r_rcv;
    logic [7:0] w_rxd;
    logic       w_dv;
    logic       w_er;
    logic       w_rcv;
    logic       w_end_trr;

    assign w_in = {rx_octet, rx_is_k, rx_code_valid};

    rx_lookahead u_la (
        .i_clk (GTX_CLK),
        .i_rst (mr_main_reset),
        .i_cg  (w_in),
        .o_cur (w_cur),
        .o_la1 (w_la1),
        .o_la2 (w_la2)
    );

    assign w_end_trr = cg_is_k(w_cur, K29_7_T) &&
                       cg_is_k(w_la1, K23_7_R) &&
                       cg_is_k(w_la2, K28_5);

    // Each state's outputs are registered on the edge that enters it, so
    // the state register names the code-group just consumed and CUR
    // already holds the next one.
    always_comb begin
        w_nxt = r_state;
        w_rxd = 8'h00;
        w_dv  = 1'b0;
        w_er  = 1'b0;
        w_rcv = 1'b0;
        if (!sync_status) begin
            w_nxt = LINK_FAILED;
            w_dv  = r_rcv;
            w_er  = r_rcv;
        end else begin
            unique case (r_state)
                LINK_FAILED: begin
                    w_nxt = WAIT_FOR_K;
                end
                WAIT_FOR_K: begin
                    if (cg_is_k(w_cur, K28_5))
                        w_nxt = RX_K;
                end
                RX_K, EARLY_END: begin
                    // EARLY_END already consumed the comma
                    w_nxt = cg_is_idle_d(w_cur) ? IDLE_D : WAIT_FOR_K;
                end
                IDLE_D: begin
                    if (cg_is_k(w_cur, K28_5)) begin
                        w_nxt = RX_K;
                    end else if (cg_is_k(w_cur, K27_7_S)) begin
                        w_nxt = START_OF_PACKET;
                        w_dv  = 1'b1;
                        w_rcv = 1'b1;
                        w_rxd = RXD_PREAMBLE;
                    end else begin
                        w_nxt = FALSE_CARRIER;
                        w_er  = 1'b1;
                        w_rxd = RXD_FALSE_CS;
                    end
                end
                FALSE_CARRIER: begin
                    if (cg_is_k(w_cur, K28_5)) begin
                        w_nxt = RX_K;
                    end else begin
                        w_er  = 1'b1;
                        w_rxd = RXD_FALSE_CS;
                    end
                end
                START_OF_PACKET, RECEIVE, RX_DATA_ERROR: begin
                    w_dv  = 1'b1;
                    w_rcv = 1'b1;
                    if (w_end_trr) begin
                        w_nxt = TRI_RRI;
                        w_dv  = 1'b0;
                        w_rcv = 1'b0;
                    end else if (cg_is_k(w_cur, K28_5)) begin
                        w_nxt = EARLY_END;
                        w_er  = 1'b1;
                    end else if (cg_is_d(w_cur)) begin
                        w_nxt = RECEIVE;
                        w_rxd = w_cur.octet;
                    end else begin
                        w_nxt = RX_DATA_ERROR;
                        w_er  = 1'b1;
                    end
                end
                TRI_RRI: begin
                    w_nxt = WAIT_FOR_K;
                end
                default: begin
                    w_nxt = LINK_FAILED;
                end
            endcase
        end
    end

    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            r_state <= LINK_FAILED;
            r_rxd   <= 8'h00;
            r_dv    <= 1'b0;
            r_er    <= 1'b0;
            r_rcv   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_rxd   <= w_rxd;
            r_dv    <= w_dv;
            r_er    <= w_er;
            r_rcv   <= w_rcv;
        end
    end

    assign RXD       = r_rxd;
    assign RX_DV     = r_dv;
    assign RX_ER     = r_er;
    assign receiving = r_rcv;

endmodule

// File: tb/tb_receive.sv
// Directed-vector bench for the PCS receive block: each code-group
// carries the hand-computed GMII output expected three cycles later.
module tb_receive;

    logic       GTX_CLK = 1'b0;
    logic       mr_main_reset;
    logic       sync_status;
    logic [7:0] rx_octet;
    logic       rx_is_k;
    logic       rx_code_valid;
    logic [7:0] RXD;
    logic       RX_DV;
    logic       RX_ER;
    logic       receiving;

    int n_checks = 0;
    int n_errors = 0;

    // {check-enable, RXD, RX_DV, RX_ER, receiving}
    logic [11:0] q_exp[$];
    string       q_tag[$];

    localparam logic [11:0] NC = 12'h000;

    receive dut (
        .GTX_CLK       (GTX_CLK),
        .mr_main_reset (mr_main_reset),
        .sync_status   (sync_status),
        .rx_octet      (rx_octet),
        .rx_is_k       (rx_is_k),
        .rx_code_valid (rx_code_valid),
        .RXD           (RXD),
        .RX_DV         (RX_DV),
        .RX_ER         (RX_ER),
        .receiving     (receiving)
    );

    always #5 GTX_CLK = ~GTX_CLK;

    function automatic logic [11:0] ex(input logic [7:0] d, input logic dv,
                                       input logic er, input logic rc);
        return {1'b1, d, dv, er, rc};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {21'd0, RXD, RX_DV, RX_ER, receiving};
    endfunction

    task automatic tick();
        @(posedge GTX_CLK);
        #1;
    endtask

    task automatic cg(input logic [7:0] o, input logic k, input logic v,
                      input logic [11:0] e, input string tag);
        logic [11:0] pe;
        string       pt;
        rx_octet      = o;
        rx_is_k       = k;
        rx_code_valid = v;
        q_exp.push_back(e);
        q_tag.push_back(tag);
        tick();
        if (q_exp.size() > 3) begin
            pe = q_exp.pop_front();
            pt = q_tag.pop_front();
            if (pe[11])
                check(pt, outs(), {21'd0, pe[10:0]});
        end
    endtask

    task automatic kc(input logic [7:0] c, input logic [11:0] e, input string t);
        cg(c, 1'b1, 1'b1, e, t);
    endtask

    task automatic dc(input logic [7:0] d, input logic [11:0] e, input string t);
        cg(d, 1'b0, 1'b1, e, t);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            kc(8'hBC, ex(8'h00, 0, 0, 0), "idle_k");
            dc(8'hC5, ex(8'h00, 0, 0, 0), "idle_d");
        end
    endtask

    task automatic flush();
        q_exp.delete();
        q_tag.delete();
    endtask

    initial begin
        mr_main_reset = 1'b1;
        sync_status   = 1'b0;
        rx_octet      = 8'h00;
        rx_is_k       = 1'b0;
        rx_code_valid = 1'b1;
        tick();
        tick();
        check("reset_out", outs(), 32'd0);

        mr_main_reset = 1'b0;
        sync_status   = 1'b1;
        idle(8);

        // normal packet
        kc(8'hFB, ex(8'h55, 1, 0, 1), "pk_sop");
        dc(8'h11, ex(8'h11, 1, 0, 1), "pk_d11");
        dc(8'h22, ex(8'h22, 1, 0, 1), "pk_d22");
        dc(8'h33, ex(8'h33, 1, 0, 1), "pk_d33");
        kc(8'hFD, ex(8'h00, 0, 0, 0), "pk_t");
        kc(8'hF7, ex(8'h00, 0, 0, 0), "pk_r");
        idle(2);

        // invalid code-group mid-packet
        kc(8'hFB, ex(8'h55, 1, 0, 1), "inv_sop");
        dc(8'hA1, ex(8'hA1, 1, 0, 1), "inv_a1");
        cg(8'h99, 1'b0, 1'b0, ex(8'h00, 1, 1, 1), "inv_err");
        dc(8'hA2, ex(8'hA2, 1, 0, 1), "inv_a2");
        dc(8'hA3, ex(8'hA3, 1, 0, 1), "inv_a3");
        kc(8'hFD, ex(8'h00, 0, 0, 0), "inv_t");
        kc(8'hF7, ex(8'h00, 0, 0, 0), "inv_r");
        idle(1);

        // early end, then idle tracking resumes
        kc(8'hFB, ex(8'h55, 1, 0, 1), "ee_sop");
        dc(8'h5A, ex(8'h5A, 1, 0, 1), "ee_d5a");
        kc(8'hBC, ex(8'h00, 1, 1, 1), "ee_k");
        dc(8'hC5, ex(8'h00, 0, 0, 0), "ee_after");
        idle(2);
        kc(8'hFB, ex(8'h55, 1, 0, 1), "ee2_sop");
        dc(8'h77, ex(8'h77, 1, 0, 1), "ee2_d77");
        kc(8'hFD, ex(8'h00, 0, 0, 0), "ee2_t");
        kc(8'hF7, ex(8'h00, 0, 0, 0), "ee2_r");
        idle(1);

        // false carrier
        dc(8'h42, ex(8'h0E, 0, 1, 0), "fc_d42");
        dc(8'h42, ex(8'h0E, 0, 1, 0), "fc_hold");
        kc(8'hFE, ex(8'h0E, 0, 1, 0), "fc_v");
        kc(8'hBC, ex(8'h00, 0, 0, 0), "fc_k");
        dc(8'hC5, ex(8'h00, 0, 0, 0), "fc_idle");
        idle(1);

        // /T/ not followed by /R/ K28.5 is a data error
        kc(8'hFB, ex(8'h55, 1, 0, 1), "trr_sop");
        dc(8'h01, ex(8'h01, 1, 0, 1), "trr_d01");
        kc(8'hFD, ex(8'h00, 1, 1, 1), "trr_t_bad");
        kc(8'hF7, ex(8'h00, 1, 1, 1), "trr_r1");
        kc(8'hF7, ex(8'h00, 1, 1, 1), "trr_r2");
        kc(8'hBC, ex(8'h00, 1, 1, 1), "trr_ee");
        dc(8'hC5, ex(8'h00, 0, 0, 0), "trr_idle");
        idle(1);

        // sync loss mid-packet
        kc(8'hFB, ex(8'h55, 1, 0, 1), "sl_sop");
        dc(8'h10, ex(8'h10, 1, 0, 1), "sl_d10");
        dc(8'h20, ex(8'h20, 1, 0, 1), "sl_d20");
        dc(8'h30, ex(8'h30, 1, 0, 1), "sl_d30");
        dc(8'h40, NC, "sl_d40");
        dc(8'h50, NC, "sl_d50");
        dc(8'h60, NC, "sl_d60");
        flush();
        sync_status = 1'b0;
        rx_octet    = 8'h70;
        rx_is_k     = 1'b0;
        tick();
        check("sl_drop", outs(), {21'd0, 8'h00, 3'b110});
        tick();
        check("sl_after1", outs(), 32'd0);
        tick();
        check("sl_after2", outs(), 32'd0);
        sync_status = 1'b1;
        idle(4);

        // reset mid-packet
        kc(8'hFB, ex(8'h55, 1, 0, 1), "rm_sop");
        dc(8'hC3, ex(8'hC3, 1, 0, 1), "rm_dc3");
        dc(8'h3C, ex(8'h3C, 1, 0, 1), "rm_d3c");
        dc(8'h99, NC, "rm_d99");
        dc(8'h98, NC, "rm_d98");
        dc(8'h97, NC, "rm_d97");
        flush();
        mr_main_reset = 1'b1;
        tick();
        check("rm_reset", outs(), 32'd0);
        mr_main_reset = 1'b0;
        tick();
        check("rm_no_er", outs(), 32'd0);
        idle(4);
        kc(8'hFB, ex(8'h55, 1, 0, 1), "rc_sop");
        dc(8'hFF, ex(8'hFF, 1, 0, 1), "rc_dff");
        kc(8'hFD, ex(8'h00, 0, 0, 0), "rc_t");
        kc(8'hF7, ex(8'h00, 0, 0, 0), "rc_r");
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/receive.md
RECEIVE -- requirements
Module: receive

Interface
REQ-001 No parameters; the module SHALL be fixed at 8-bit GMII data and a 2-code-group lookahead.
REQ-002 GTX_CLK  in  1  single clock; all state changes on the rising edge.
REQ-003 mr_main_reset  in  1  reset, synchronous, active-high.
REQ-004 sync_status  in  1  code-group alignment acquired (1 = OK).
REQ-005 rx_octet  in  8  decoded code-group value from the decoder.
REQ-006 rx_is_k  in  1  1 = control (K) code-group, 0 = data (D).
REQ-007 rx_code_valid  in  1  0 = invalid code-group or disparity error.
REQ-008 RXD  out  8  GMII receive data.
REQ-009 RX_DV  out  1  GMII receive data valid.
REQ-010 RX_ER  out  1  GMII receive error.
REQ-011 receiving  out  1  a packet is in progress (carrier sense to upper layer).

Function
REQ-012 Every rising edge SHALL shift input triple {rx_octet, rx_is_k, rx_code_valid} through lookahead stages LA2 -> LA1 -> CUR; the FSM evaluates CUR with LA1 and LA2 visible.
REQ-013 Outputs SHALL be registered; input-to-RXD latency is exactly 3 cycles.
REQ-014 Codes: K28.5 = 0xBC; /S/ = K27.7 = 0xFB; /T/ = K29.7 = 0xFD; /R/ = K23.7 = 0xF7; /V/ = K30.7 = 0xFE; idle D = 0xC5 (/I1/) or 0x50 (/I2/).
REQ-015 States: LINK_FAILED, WAIT_FOR_K, RX_K, IDLE_D, FALSE_CARRIER, START_OF_PACKET, RECEIVE, RX_DATA_ERROR, EARLY_END, TRI_RRI.
REQ-016 LINK_FAILED: -> WAIT_FOR_K when sync_status = 1; outputs RX_DV = 0, RX_ER = 0, receiving = 0.
REQ-017 WAIT_FOR_K: CUR = K28.5 -> RX_K; otherwise stay.
REQ-018 RX_K: CUR is a valid D equal to 0xC5 or 0x50 -> IDLE_D; anything else -> WAIT_FOR_K.
REQ-019 IDLE_D, on CUR:
- K28.5 -> RX_K.
- /S/ -> START_OF_PACKET.
- any other code-group -> FALSE_CARRIER.
REQ-020 START_OF_PACKET: drive RX_DV = 1, RX_ER = 0, RXD = 0x55, receiving = 1, then -> RECEIVE.
REQ-021 RECEIVE, on CUR; first match wins:
- /T/ with LA1 = /R/ and LA2 = K28.5 -> TRI_RRI.
- K28.5 -> EARLY_END.
- valid D -> RXD = CUR, RX_DV = 1, RX_ER = 0, stay.
- otherwise -> RX_DATA_ERROR.
REQ-022 RX_DATA_ERROR: drive RX_DV = 1, RX_ER = 1, RXD = 0x00 for one cycle; then evaluate the next CUR as RECEIVE does.
REQ-023 EARLY_END: drive RX_DV = 1, RX_ER = 1 for one cycle, then receiving = 0 and -> RX_K (K28.5 already consumed).
REQ-024 TRI_RRI: drive RX_DV = 0, RX_ER = 0, receiving = 0, then -> WAIT_FOR_K.
REQ-025 FALSE_CARRIER: drive RX_DV = 0, RX_ER = 1, RXD = 0x0E; -> RX_K on CUR = K28.5, otherwise stay.
REQ-026 sync_status = 0 in any state SHALL force LINK_FAILED on the next edge.
REQ-027 If receiving was 1 when sync_status drops, the first LINK_FAILED cycle SHALL drive RX_DV = 1, RX_ER = 1; afterwards RX_DV = 0, RX_ER = 0.
REQ-028 In states that do not specify RXD, RXD SHALL be 0x00.

Reset
REQ-029 With mr_main_reset = 1 at an edge, outputs SHALL be: state = LINK_FAILED, lookahead stages cleared to D 0x00 valid, RXD = 0x00, RX_DV = 0, RX_ER = 0, receiving = 0.
REQ-030 Reset asserted mid-packet SHALL abort the packet with no RX_ER pulse.

Structure
REQ-031 The code constants and the state encoding SHALL live in the shared PCS definitions include, alongside the transmit-side constants.
REQ-032 The lookahead shift register SHALL be a sub-module named rx_lookahead; the FSM and output registers stay in receive.

Verification
REQ-033 Reset, then sync_status = 1 with K28.5/0xC5 pairs -> RX_DV = 0, RX_ER = 0, receiving = 0 throughout.
REQ-034 Idle, then /S/, D 0x11 0x22 0x33, /T/ /R/ K28.5 -> RXD 0x55 0x11 0x22 0x33 with RX_DV = 1, 3 cycles after each input; then RX_DV = 0.
REQ-035 Mid-packet rx_code_valid = 0 for one code-group -> exactly one cycle of RX_DV = 1, RX_ER = 1, RXD = 0x00; the following data continues.
REQ-036 Mid-packet K28.5 without /T/ -> one cycle RX_ER = 1, then receiving = 0 and idle tracking resumes.
REQ-037 After idle D, a D 0x42 code-group -> RX_ER = 1, RXD = 0x0E until the next K28.5.
REQ-038 sync_status dropped mid-packet -> one cycle RX_DV = 1, RX_ER = 1, then all outputs 0; mr_main_reset mid-packet -> all outputs 0 on the next edge.
